// File: rtl/glyph_blitter.sv
// Serialises a 25x25 monochrome glyph into a magnified (x, y, ink) pixel stream.
// The glyph is snapshotted on start and walked in raster order over a valid/ready handshake.
module glyph_blitter #(
  parameter int SCALE     = 1,
  parameter int COORD_W   = 10,
  parameter int INK_LEVEL = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [24:0]        ishape [0:24],
  input  logic               start,
  input  logic               abort,
  input  logic [COORD_W-1:0] org_x,
  input  logic [COORD_W-1:0] org_y,
  output logic               px_valid,
  input  logic               px_ready,
  output logic [COORD_W-1:0] px_x,
  output logic [COORD_W-1:0] px_y,
  output logic               px_ink,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [2:0] SUB_MAX = 3'(SCALE - 1);
  localparam logic [4:0] EDGE    = 5'd24;
  localparam logic       INK_BIT = (INK_LEVEL != 0);

  state_t state_reg, state_next;

  logic [24:0]        snap_reg [0:24];
  logic [COORD_W-1:0] org_x_reg;
  logic [COORD_W-1:0] x_reg;
  logic [COORD_W-1:0] y_reg;
  logic [4:0]         r_reg;
  logic [4:0]         c_reg;
  logic [2:0]         sr_reg;
  logic [2:0]         sc_reg;

  logic        launch;
  logic        xfer;
  logic        sc_wrap;
  logic        c_wrap;
  logic        sr_wrap;
  logic        r_last;
  logic        last_beat;
  logic [24:0] cur_row;
  logic [4:0]  col_bit;

  assign launch    = (state_reg == IDLE) && start;
  assign xfer      = (state_reg == EMIT) && px_ready;
  assign sc_wrap   = (sc_reg == SUB_MAX);
  assign c_wrap    = (c_reg == EDGE);
  assign sr_wrap   = (sr_reg == SUB_MAX);
  assign r_last    = (r_reg == EDGE);
  assign last_beat = r_last && sr_wrap && c_wrap && sc_wrap;

  // Bit 24 of each row is the leftmost column.
  assign cur_row = snap_reg[r_reg];
  assign col_bit = EDGE - c_reg;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = EMIT;
        end
      end
      EMIT: begin
        // Abort wins even over a final transfer in the same cycle.
        if (abort) begin
          state_next = IDLE;
        end else if (xfer && last_beat) begin
          state_next = FIN;
        end
      end
      FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    px_valid = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    px_ink   = 1'b0;
    unique case (state_reg)
      EMIT: begin
        px_valid = 1'b1;
        busy     = 1'b1;
        px_ink   = (cur_row[col_bit] == INK_BIT);
      end
      FIN: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Glyph snapshot: isolates the stream from later ishape changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 25; i++) begin
        snap_reg[i] <= '0;
      end
    end else if (launch) begin
      for (int i = 0; i < 25; i++) begin
        snap_reg[i] <= ishape[i];
      end
    end
  end

  // Raster counters. x and y are tracked incrementally so no multiply is needed:
  // x steps by one on every beat and returns to org_x at the end of each scaled line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      org_x_reg <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
      r_reg     <= '0;
      c_reg     <= '0;
      sr_reg    <= '0;
      sc_reg    <= '0;
    end else if (launch) begin
      org_x_reg <= org_x;
      x_reg     <= org_x;
      y_reg     <= org_y;
      r_reg     <= '0;
      c_reg     <= '0;
      sr_reg    <= '0;
      sc_reg    <= '0;
    end else if (xfer && !last_beat) begin
      if (!sc_wrap) begin
        sc_reg <= sc_reg + 3'd1;
        x_reg  <= x_reg + 1'b1;
      end else begin
        sc_reg <= '0;
        if (!c_wrap) begin
          c_reg <= c_reg + 5'd1;
          x_reg <= x_reg + 1'b1;
        end else begin
          c_reg <= '0;
          x_reg <= org_x_reg;
          y_reg <= y_reg + 1'b1;
          if (!sr_wrap) begin
            sr_reg <= sr_reg + 3'd1;
          end else begin
            sr_reg <= '0;
            r_reg  <= r_reg + 5'd1;
          end
        end
      end
    end
  end

  assign px_x = x_reg;
  assign px_y = y_reg;

endmodule
